// File: rtl/pulse_sched.sv
// pulse_sched -- four-channel periodic / one-shot event scheduler.
//
// A prescaler divides clk down to a timebase tick (PRESCALE = TICK_NS /
// CLK_PERIOD, minimum 1). Each channel counts ticks and fires every
// `period` ticks. A fire sets the channel's pending flag. A round-robin
// arbiter presents pending channels one at a time on a valid/ready handshake.
//
// Parameters:
//   CLK_PERIOD  clock period in ns
//   TICK_NS     timebase tick interval in ns
//   PERIOD_W    width of the channel period field
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   cfg_we       config write strobe (one cycle per write)
//   cfg_ch       channel written (0-3)
//   cfg_period   period in ticks (0 behaves as 1)
//   cfg_oneshot  1 = fire once then disable, 0 = periodic
//   cfg_en       channel enable
//   evt_valid    an event is being presented
//   evt_ch       channel of the presented event
//   evt_ready    consumer accepts the presented event
//   ch_active    registered per-channel enable bits
//   ovf_cnt      saturating count of dropped (overrun) fires
//
// Build option:
//   PULSE_SCHED_OVF_CNT_EN  when defined, adds the ovf_cnt port and counter.
//                           When undefined, overruns are silently dropped.

module pulse_sched #(
    parameter int CLK_PERIOD = 5,
    parameter int TICK_NS    = 1000,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_oneshot,
    input  logic                cfg_en,
    output logic                evt_valid,
    output logic [1:0]          evt_ch,
    input  logic                evt_ready,
    output logic [3:0]          ch_active
`ifdef PULSE_SCHED_OVF_CNT_EN
    ,
    output logic [7:0]          ovf_cnt
`endif
);

    localparam int PRESCALE_RAW = TICK_NS / CLK_PERIOD;
    localparam int PRESCALE     = (PRESCALE_RAW < 1) ? 1 : PRESCALE_RAW;
    localparam int PS_W         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } arb_state_e;

    logic [PS_W-1:0]     ps_q, ps_d;
    logic                tick;

    logic [PERIOD_W-1:0] period_q [4];
    logic [PERIOD_W-1:0] period_d [4];
    logic [PERIOD_W-1:0] cnt_q    [4];
    logic [PERIOD_W-1:0] cnt_d    [4];
    logic [3:0]          en_q, en_d;
    logic [3:0]          os_q, os_d;
    logic [3:0]          pend_q, pend_d;
    logic [3:0]          fire;
    logic [3:0]          wr_hit;

    arb_state_e          state_q, state_d;
    logic [1:0]          evt_ch_q, evt_ch_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          cand;
    logic                found;
    logic                handshake;

`ifdef PULSE_SCHED_OVF_CNT_EN
    logic [7:0]          ovf_q, ovf_d;
    logic [2:0]          ovr_n;
    logic [8:0]          ovf_sum;
`endif

    // Prescaler: with PRESCALE = 1 the counter sits at 0 and tick is constant 1.
    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    // Per-channel configuration, tick counting and pending flags.
    always_comb begin
        // NOTE: every combinational output is given its default first, so no
        // path through the block leaves it unassigned and no latch is inferred.
        en_d      = en_q;
        os_d      = os_q;
        pend_d    = pend_q;
        fire      = '0;
        wr_hit    = '0;
        handshake = (state_q == PRESENT) && evt_ready;
        for (int i = 0; i < 4; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
        end

        for (int i = 0; i < 4; i++) begin
            wr_hit[i] = cfg_we && (cfg_ch == 2'(i));
            if (wr_hit[i]) begin
                // A write overrides any tick on the same channel this cycle.
                period_d[i] = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
                os_d[i]     = cfg_oneshot;
                en_d[i]     = cfg_en;
                cnt_d[i]    = '0;
                pend_d[i]   = 1'b0;
            end else begin
                if (tick && en_q[i]) begin
                    if (cnt_q[i] == period_q[i] - PERIOD_W'(1)) begin
                        fire[i]  = 1'b1;
                        cnt_d[i] = '0;
                        if (os_q[i]) begin
                            en_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
                    end
                end
                if (handshake && (evt_ch_q == 2'(i))) begin
                    pend_d[i] = 1'b0;
                end
                // A fire during the channel's own handshake re-arms it as a
                // fresh event; otherwise a fire onto a set flag is an overrun.
                if (fire[i]) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

`ifdef PULSE_SCHED_OVF_CNT_EN
    always_comb begin
        ovr_n = '0;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && pend_q[i] && !(handshake && (evt_ch_q == 2'(i)))) begin
                ovr_n = ovr_n + 3'd1;
            end
        end
        ovf_sum = {1'b0, ovf_q} + {6'd0, ovr_n};
        ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end
`endif

    // Arbiter: round-robin search starting one past the last granted channel.
    always_comb begin
        state_d  = state_q;
        evt_ch_d = evt_ch_q;
        last_d   = last_q;
        found    = 1'b0;
        cand     = '0;
        case (state_q)
            IDLE: begin
                for (int off = 1; off <= 4; off++) begin
                    cand = last_q + 2'(off);
                    if (!found && pend_q[cand]) begin
                        evt_ch_d = cand;
                        found    = 1'b1;
                    end
                end
                if (found) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    state_d = IDLE;
                    last_d  = evt_ch_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q     <= '0;
            en_q     <= '0;
            os_q     <= '0;
            pend_q   <= '0;
            // NOTE: the small period/count arrays are reset element by element
            // so a channel enabled without a prior write behaves as period 1.
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= PERIOD_W'(1);
                cnt_q[i]    <= '0;
            end
            state_q  <= IDLE;
            evt_ch_q <= '0;
            last_q   <= 2'd3;
`ifdef PULSE_SCHED_OVF_CNT_EN
            ovf_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, so every flop updates from the
            // same pre-edge values regardless of statement order.
            ps_q     <= ps_d;
            en_q     <= en_d;
            os_q     <= os_d;
            pend_q   <= pend_d;
            for (int i = 0; i < 4; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            state_q  <= state_d;
            evt_ch_q <= evt_ch_d;
            last_q   <= last_d;
`ifdef PULSE_SCHED_OVF_CNT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign evt_valid = (state_q == PRESENT);
    assign evt_ch    = evt_ch_q;
    assign ch_active = en_q;
`ifdef PULSE_SCHED_OVF_CNT_EN
    assign ovf_cnt   = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched.
// Two instances share one stimulus stream: dut_a ticks every 4 clocks
// (TICK_NS=20, CLK_PERIOD=5), and dut_b ticks every clock (TICK_NS=5).
// A behavioural model tracks "ticks remaining until fire" per channel. It
// derives the tick from the cycle count since reset. Its outputs are compared
// to both instances every cycle. Directed literal checks pin the model.

module tb_pulse_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_period;
    logic        cfg_oneshot;
    logic        cfg_en;
    logic        evt_ready;

    logic        a_valid, b_valid;
    logic [1:0]  a_ch, b_ch;
    logic [3:0]  a_act, b_act;
`ifdef PULSE_SCHED_OVF_CNT_EN
    logic [7:0]  a_ovf, b_ovf;
`endif

    always #5 clk = ~clk;

    pulse_sched #(.CLK_PERIOD(5), .TICK_NS(20), .PERIOD_W(16)) dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .cfg_en(cfg_en),
        .evt_valid(a_valid), .evt_ch(a_ch), .evt_ready(evt_ready),
        .ch_active(a_act)
`ifdef PULSE_SCHED_OVF_CNT_EN
        , .ovf_cnt(a_ovf)
`endif
    );

    pulse_sched #(.CLK_PERIOD(5), .TICK_NS(5), .PERIOD_W(16)) dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot), .cfg_en(cfg_en),
        .evt_valid(b_valid), .evt_ch(b_ch), .evt_ready(evt_ready),
        .ch_active(b_act)
`ifdef PULSE_SCHED_OVF_CNT_EN
        , .ovf_cnt(b_ovf)
`endif
    );

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) -------
    int m_cyc    [2];
    int m_period [2][4];
    int m_rem    [2][4];
    bit m_os     [2][4];
    bit m_en     [2][4];
    bit m_pend   [2][4];
    bit m_pres   [2];
    int m_pch    [2];
    int m_last   [2];
    int m_ovf    [2];

    int total = 0;
    int bad   = 0;
    int tb_cyc = 0;
    int hs_cnt [2][4];
    int grants_a[$];
    int grants_b[$];
    int a_ch0_times[$];

    function automatic int prescale_of(input int k);
        return (k == 0) ? 20 / 5 : 5 / 5;
    endfunction

    function automatic logic [31:0] act_of(input int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = m_en[k][i];
        return v;
    endfunction

    task automatic m_reset(input int k);
        m_cyc[k] = 0;
        for (int i = 0; i < 4; i++) begin
            m_period[k][i] = 1;
            m_rem[k][i]    = 1;
            m_os[k][i]     = 1'b0;
            m_en[k][i]     = 1'b0;
            m_pend[k][i]   = 1'b0;
        end
        m_pres[k] = 1'b0;
        m_pch[k]  = 0;
        m_last[k] = 3;
        m_ovf[k]  = 0;
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic m_step(input int k);
        bit old_pend[4];
        bit tick, hs, fire;
        int nov, p, j;
        if (reset) begin
            m_reset(k);
            return;
        end
        p    = prescale_of(k);
        tick = ((m_cyc[k] % p) == p - 1);
        m_cyc[k]++;
        hs   = m_pres[k] && evt_ready;
        nov  = 0;
        for (int i = 0; i < 4; i++) old_pend[i] = m_pend[k][i];
        for (int i = 0; i < 4; i++) begin
            fire = 1'b0;
            if (cfg_we && (cfg_ch == 2'(i))) begin
                m_period[k][i] = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
                m_os[k][i]     = cfg_oneshot;
                m_en[k][i]     = cfg_en;
                m_rem[k][i]    = m_period[k][i];
                m_pend[k][i]   = 1'b0;
            end else begin
                if (tick && m_en[k][i]) begin
                    if (m_rem[k][i] == 1) begin
                        fire = 1'b1;
                        m_rem[k][i] = m_period[k][i];
                        if (m_os[k][i]) m_en[k][i] = 1'b0;
                    end else begin
                        m_rem[k][i]--;
                    end
                end
                if (fire) begin
                    if (old_pend[i] && !(hs && m_pch[k] == i)) nov++;
                    m_pend[k][i] = 1'b1;
                end else if (hs && m_pch[k] == i) begin
                    m_pend[k][i] = 1'b0;
                end
            end
        end
        m_ovf[k] = (m_ovf[k] + nov > 255) ? 255 : m_ovf[k] + nov;
        if (m_pres[k]) begin
            if (evt_ready) begin
                m_pres[k] = 1'b0;
                m_last[k] = m_pch[k];
            end
        end else begin
            for (int off = 1; off <= 4; off++) begin
                j = (m_last[k] + off) % 4;
                if (!m_pres[k] && old_pend[j]) begin
                    m_pres[k] = 1'b1;
                    m_pch[k]  = j;
                end
            end
        end
    endtask

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tb_cyc);
        end
    endtask

    // Per-cycle comparison against the model, plus logging of DUT handshakes.
    task automatic compare_cycle();
        check("a_valid", 32'(a_valid), 32'(m_pres[0]));
        check("a_ch",    32'(a_ch),    32'(m_pch[0]));
        check("a_act",   32'(a_act),   act_of(0));
        check("b_valid", 32'(b_valid), 32'(m_pres[1]));
        check("b_ch",    32'(b_ch),    32'(m_pch[1]));
        check("b_act",   32'(b_act),   act_of(1));
`ifdef PULSE_SCHED_OVF_CNT_EN
        check("a_ovf",   32'(a_ovf),   32'(m_ovf[0]));
        check("b_ovf",   32'(b_ovf),   32'(m_ovf[1]));
`endif
        if (a_valid === 1'b1 && evt_ready) begin
            hs_cnt[0][a_ch]++;
            grants_a.push_back(int'(a_ch));
        end
        if (b_valid === 1'b1 && evt_ready) begin
            hs_cnt[1][b_ch]++;
            grants_b.push_back(int'(b_ch));
        end
        if (a_valid === 1'b1 && a_ch == 2'd0) a_ch0_times.push_back(tb_cyc);
    endtask

    // One clock: compare at the falling edge, advance the model, then return
    // just after the rising edge so inputs change away from it.
    task automatic step();
        @(negedge clk);
        compare_cycle();
        m_step(0);
        m_step(1);
        @(posedge clk);
        #1;
        tb_cyc++;
    endtask

    task automatic cfg(input int ch, input int per, input bit os, input bit en);
        cfg_we      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_period  = 16'(per);
        cfg_oneshot = os;
        cfg_en      = en;
        step();
        cfg_we      = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ------------------------------------
    initial begin
        int n0, na, nb, viol, h_a, h_b, hs_a0, hs_b0, hs_a1, hs_b1;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_oneshot = 1'b0; cfg_en = 1'b0; evt_ready = 1'b0;
        m_reset(0);
        m_reset(1);
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_a_ch",    32'(a_ch),    32'd0);
        check("rst_a_act",   32'(a_act),   32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_b_act",   32'(b_act),   32'd0);
`ifdef PULSE_SCHED_OVF_CNT_EN
        check("rst_a_ovf",   32'(a_ovf),   32'd0);
`endif

        // ch0 period 3 periodic with 4-clock ticks: one event every 12 cycles.
        evt_ready = 1'b1;
        n0 = a_ch0_times.size();
        cfg(0, 3, 1'b0, 1'b1);
        repeat (40) step();
        check("per3_pulse_count_ge3", 32'(a_ch0_times.size() - n0 >= 3), 32'd1);
        if (a_ch0_times.size() - n0 >= 3) begin
            check("per3_interval1", 32'(a_ch0_times[n0+1] - a_ch0_times[n0]),   32'd12);
            check("per3_interval2", 32'(a_ch0_times[n0+2] - a_ch0_times[n0+1]), 32'd12);
        end

        // ch1 period 2 oneshot: exactly one event, then disabled.
        cfg(0, 3, 1'b0, 1'b0);
        repeat (4) step();
        h_a = hs_cnt[0][1];
        h_b = hs_cnt[1][1];
        cfg(1, 2, 1'b1, 1'b1);
        repeat (20) step();
        check("oneshot_a_events", 32'(hs_cnt[0][1] - h_a), 32'd1);
        check("oneshot_b_events", 32'(hs_cnt[1][1] - h_b), 32'd1);
        check("oneshot_a_active", 32'(a_act[1]), 32'd0);
        check("oneshot_b_active", 32'(b_act[1]), 32'd0);

        // All four channels period 1: grants rotate 0,1,2,3.
        for (int i = 0; i < 4; i++) cfg(i, 1, 1'b0, 1'b1);
        repeat (8) step();
        na = grants_a.size();
        nb = grants_b.size();
        repeat (32) step();
        viol = 0;
        for (int n = na; n + 1 < grants_a.size(); n++)
            if (((grants_a[n+1] - grants_a[n]) & 3) != 1) viol++;
        check("rr_a_order_violations", 32'(viol), 32'd0);
        check("rr_a_grants_ge12", 32'(grants_a.size() - na >= 12), 32'd1);
        viol = 0;
        for (int n = nb; n + 1 < grants_b.size(); n++)
            if (((grants_b[n+1] - grants_b[n]) & 3) != 1) viol++;
        check("rr_b_order_violations", 32'(viol), 32'd0);
        check("rr_b_grants_ge12", 32'(grants_b.size() - nb >= 12), 32'd1);
        for (int i = 0; i < 4; i++) cfg(i, 1, 1'b0, 1'b0);
        repeat (4) step();

        // ch2 period 1, tick every clock, consumer stalled: event held, overruns counted.
        reset_pulse();
        evt_ready = 1'b0;
        cfg(2, 1, 1'b0, 1'b1);
        repeat (10) step();
        check("stall_b_valid", 32'(b_valid), 32'd1);
        check("stall_b_ch",    32'(b_ch),    32'd2);
`ifdef PULSE_SCHED_OVF_CNT_EN
        check("stall_b_ovf",   32'(b_ovf),   32'd9);
`endif
        // Rewriting the presented channel leaves the in-flight event intact.
        cfg(2, 1, 1'b0, 1'b0);
        check("inflight_b_valid",  32'(b_valid),  32'd1);
        check("inflight_b_ch",     32'(b_ch),     32'd2);
        check("inflight_b_active", 32'(b_act[2]), 32'd0);
        evt_ready = 1'b1;
        step();
        check("inflight_b_done",   32'(b_valid),  32'd0);
        step();
        check("inflight_b_idle",   32'(b_valid),  32'd0);

        // A write coincident with the fire tick suppresses it; next fire 3 ticks later.
        reset_pulse();
        evt_ready = 1'b1;
        cfg(0, 3, 1'b0, 1'b1);
        step();
        step();
        cfg(0, 3, 1'b0, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            step();
            check($sformatf("rewrite_b_valid_%0d", j), 32'(b_valid), 32'(j == 4));
        end
        check("rewrite_b_ch", 32'(b_ch), 32'd0);

        // Reset during a stalled presentation drops the event.
        cfg(0, 3, 1'b0, 1'b0);
        repeat (3) step();
        evt_ready = 1'b0;
        cfg(3, 1, 1'b0, 1'b1);
        repeat (8) step();
        check("prerst_a_valid", 32'(a_valid), 32'd1);
        check("prerst_a_ch",    32'(a_ch),    32'd3);
        check("prerst_b_valid", 32'(b_valid), 32'd1);
        check("prerst_b_ch",    32'(b_ch),    32'd3);
        reset = 1'b1;
        step();
        check("midrst_a_valid", 32'(a_valid), 32'd0);
        check("midrst_a_act",   32'(a_act),   32'd0);
        check("midrst_b_valid", 32'(b_valid), 32'd0);
        check("midrst_b_act",   32'(b_act),   32'd0);
        reset = 1'b0;
        evt_ready = 1'b1;
        hs_a0 = 0;
        hs_b0 = 0;
        for (int i = 0; i < 4; i++) begin
            hs_a0 += hs_cnt[0][i];
            hs_b0 += hs_cnt[1][i];
        end
        repeat (20) step();
        hs_a1 = 0;
        hs_b1 = 0;
        for (int i = 0; i < 4; i++) begin
            hs_a1 += hs_cnt[0][i];
            hs_b1 += hs_cnt[1][i];
        end
        check("postrst_a_events", 32'(hs_a1 - hs_a0), 32'd0);
        check("postrst_b_events", 32'(hs_b1 - hs_b0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
